decode_ctrl_pipe: RTL

Registered, multi-lane successor to the combinational decode controller. Decodes LANES 32-bit RV32I instruction words per bundle into the control set consumed by EX/MEM/WB (ALU source, load/store type, writeback enables, invalid flag). Sits between fetch and the ID/EX boundary with valid/ready handshakes on both sides and a 2-entry skid buffer. It also supports flush and keeps a saturating illegal-instruction counter.

---
 rtl/decode_pkg.sv | 58 +++++
 rtl/decode_lane.sv | 74 +++++++
 rtl/decode_ctrl_pipe.sv | 136 +++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode constants, load/store codes and the per-lane control bundle
// carried through the decode pipe.
package decode_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] LT_LB   = 3'b000;
    localparam logic [2:0] LT_LH   = 3'b001;
    localparam logic [2:0] LT_LW   = 3'b010;
    localparam logic [2:0] LT_LBU  = 3'b011;
    localparam logic [2:0] LT_LHU  = 3'b100;
    localparam logic [2:0] LT_NONE = 3'b111;

    localparam logic [1:0] ST_SB   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SW   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_FULL  = 2'd1,
        BUF_SKID  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic [2:0] load_type;
        logic [1:0] store_type;
        logic       wb_load;
        logic       wb_reg_file;
        logic       invalid;
        logic       muldiv;
        logic [4:0] rd;
    } ctrl_t;

    // Control word seen on the outputs out of reset: nothing enabled, no load/store.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c            = '0;
        c.load_type  = LT_NONE;
        c.store_type = ST_NONE;
        return c;
    endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational RV32I decode of one instruction word into ctrl_t.
// RV_MEXT_EN: when defined, R-type func7=0000001 (M extension) decodes as legal muldiv.
module decode_lane
    import decode_pkg::*;
(
    input  logic [31:0] inst_i,
    output ctrl_t       ctrl_o
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       is_r, is_md, is_i, is_jalr, is_b, is_jal, is_auipc, is_lui;
    logic       ld_ok, st_ok, legal;
    logic [2:0] lt;
    logic [1:0] st;
    logic       unused_bits;

    assign opcode      = inst_i[6:0];
    assign func3       = inst_i[14:12];
    assign func7       = inst_i[31:25];
    assign unused_bits = ^inst_i[24:15];

    assign is_r     = (opcode == OP_R) && ((func7 == F7_BASE) || (func7 == F7_ALT));
`ifdef RV_MEXT_EN
    assign is_md    = (opcode == OP_R) && (func7 == F7_MULDIV);
`else
    assign is_md    = 1'b0;
`endif
    assign is_i     = (opcode == OP_I);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_b     = (opcode == OP_B);
    assign is_jal   = (opcode == OP_JAL);
    assign is_auipc = (opcode == OP_AUIPC);
    assign is_lui   = (opcode == OP_LUI);

    always_comb begin
        lt = LT_NONE;
        case (func3)
            3'b000:  lt = LT_LB;
            3'b001:  lt = LT_LH;
            3'b010:  lt = LT_LW;
            3'b100:  lt = LT_LBU;
            3'b101:  lt = LT_LHU;
            default: lt = LT_NONE;
        endcase
        st = ST_NONE;
        case (func3)
            3'b000:  st = ST_SB;
            3'b001:  st = ST_SH;
            3'b010:  st = ST_SW;
            default: st = ST_NONE;
        endcase
    end

    assign ld_ok = (opcode == OP_LOAD) && (lt != LT_NONE);
    assign st_ok = (opcode == OP_S) && (st != ST_NONE);
    assign legal = is_r | is_md | is_i | ld_ok | st_ok | is_lui | is_auipc | is_jalr | is_b | is_jal;

    // Every enable below is built only from legal terms, so an invalid lane drives them all low.
    always_comb begin
        ctrl_o             = ctrl_idle();
        ctrl_o.rd          = inst_i[11:7];
        ctrl_o.invalid     = ~legal;
        ctrl_o.alu_src     = is_i | ld_ok | st_ok | is_lui | is_auipc | is_jalr;
        ctrl_o.mem_write   = st_ok;
        ctrl_o.wb_load     = ld_ok;
        ctrl_o.wb_reg_file = is_r | is_md | is_i | ld_ok | is_lui | is_auipc | is_jalr | is_jal;
        ctrl_o.muldiv      = is_md;
        ctrl_o.load_type   = ld_ok ? lt : LT_NONE;
        ctrl_o.store_type  = st_ok ? st : ST_NONE;
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered LANES-wide decode stage with 2-entry skid buffer and saturating illegal counter.
// Latency 1 cycle; in_ready drops the cycle after the skid entry fills. RV_MEXT_EN enables M decode.
module decode_ctrl_pipe
    import decode_pkg::*;
#(
    parameter int LANES = 1,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*LANES-1:0]  in_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_alu_src,
    output logic [LANES-1:0]     out_mem_write,
    output logic [LANES-1:0]     out_wb_load,
    output logic [LANES-1:0]     out_wb_reg_file,
    output logic [LANES-1:0]     out_invalid,
    output logic [LANES-1:0]     out_muldiv,
    output logic [3*LANES-1:0]   out_load_type,
    output logic [2*LANES-1:0]   out_store_type,
    output logic [5*LANES-1:0]   out_rd,
    output logic [CNT_W-1:0]     illegal_cnt,
    output logic                 illegal_seen
);

    localparam logic [CNT_W+2:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

    buf_state_e              state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    ctrl_t [LANES-1:0]       dec, main_q, main_d, skid_q, skid_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    seen_q, seen_d;
    logic                    accept;
    logic [2:0]              pop_inv;
    logic [CNT_W+2:0]        sum;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        decode_lane u_lane (
            .inst_i (in_inst[32*l +: 32]),
            .ctrl_o (dec[l])
        );
        assign out_alu_src[l]          = main_q[l].alu_src;
        assign out_mem_write[l]        = main_q[l].mem_write;
        assign out_wb_load[l]          = main_q[l].wb_load;
        assign out_wb_reg_file[l]      = main_q[l].wb_reg_file;
        assign out_invalid[l]          = main_q[l].invalid;
        assign out_muldiv[l]           = main_q[l].muldiv;
        assign out_load_type[3*l +: 3] = main_q[l].load_type;
        assign out_store_type[2*l +: 2]= main_q[l].store_type;
        assign out_rd[5*l +: 5]        = main_q[l].rd;
    end

    assign in_ready     = in_ready_q & ~flush_i;
    assign out_valid    = (state_q != BUF_EMPTY);
    assign accept       = in_valid & in_ready;
    assign illegal_cnt  = cnt_q;
    assign illegal_seen = seen_q;

    // main_q always holds the oldest bundle; skid_q only the one that arrived behind a stall.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d = BUF_FULL;
                        main_d  = dec;
                    end
                end
                BUF_FULL: begin
                    if (accept && !out_ready) begin
                        state_d = BUF_SKID;
                        skid_d  = dec;
                    end else if (accept) begin
                        main_d  = dec;
                    end else if (out_ready) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_SKID: begin
                    if (out_ready) begin
                        state_d = BUF_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
        in_ready_d = (state_d != BUF_SKID);
    end

    always_comb begin
        pop_inv = 3'd0;
        for (int l = 0; l < LANES; l++) begin
            pop_inv = pop_inv + 3'(dec[l].invalid);
        end
        sum    = {3'b000, cnt_q} + {{CNT_W{1'b0}}, pop_inv};
        cnt_d  = cnt_q;
        seen_d = seen_q;
        if (accept) begin
            cnt_d = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
            if (pop_inv != 3'd0) begin
                seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                main_q[l] <= ctrl_idle();
                skid_q[l] <= ctrl_idle();
            end
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

endmodule
